icache_tag_sram_ctrl: RTL and testbench
=======================================

ICACHE_TAG_SRAM_CTRL -- requirements
Module: icache_tag_sram_ctrl

Interface
REQ-001 SHALL have parameter NumWords, default 64: tag SRAM depth; power of two, >=2.
REQ-002 SHALL have parameter DataWidth, default 8: tag SRAM word; bit DataWidth-1 = valid, bits DataWidth-2:0 = tag; >=2.
REQ-003 SHALL derive AW = $clog2(NumWords), TW = DataWidth-1, BW = (DataWidth+7)/8.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clk_i  in  1  clock; all state updates on rising edge.
REQ-006 rst_i  in  1  synchronous active-high reset.
REQ-007 flush_req_i  in  1  request invalidation of all entries.
REQ-008 busy_o  out  1  high while reset asserted or flush sweep in progress.
REQ-009 lookup_req_i / lookup_gnt_o  in/out  1  lookup handshake.
REQ-010 lookup_addr_i  in  AW; lookup_tag_i  in  TW.
REQ-011 lookup_rvalid_o / lookup_hit_o  out  1  lookup result strobe and hit flag.
REQ-012 refill_req_i / refill_gnt_o  in/out  1  tag-write handshake.
REQ-013 refill_addr_i  in  AW; refill_tag_i  in  TW.
REQ-014 sram_req_o, sram_we_o  out  1; sram_addr_o  out  AW; sram_wdata_o  out  DataWidth; sram_be_o  out  BW  SRAM port.
REQ-015 sram_rdata_i  in  DataWidth  read data, valid exactly one cycle after a read request.

Function
REQ-016 States SHALL be FLUSH and IDLE; reset enters FLUSH with sweep counter = 0.
REQ-017 FLUSH: each cycle sram_req_o=1, sram_we_o=1, sram_addr_o=counter, sram_wdata_o=0; counter increments.
REQ-018 Sweep SHALL write the NumWords-1 entry then go IDLE; counter does not wrap; sweep = exactly NumWords cycles.
REQ-019 sram_be_o SHALL be all ones whenever sram_req_o=1, otherwise 0.
REQ-020 In FLUSH, lookup_gnt_o and refill_gnt_o SHALL be 0; flush_req_i ignored.
REQ-021 IDLE priority: flush_req_i > refill_req_i > lookup_req_i; at most one SRAM access per cycle.
REQ-022 IDLE with flush_req_i=1: no grant that cycle; FLUSH entered next cycle, counter = 0.
REQ-023 Refill grant: refill_gnt_o=1 combinationally, same cycle sram_req_o=1, sram_we_o=1, addr=refill_addr_i, wdata={1'b1, refill_tag_i}.
REQ-024 Lookup grant: lookup_gnt_o=1 combinationally, same cycle sram_req_o=1, sram_we_o=0, addr=lookup_addr_i; lookup_tag_i registered.
REQ-025 lookup_rvalid_o SHALL pulse exactly one cycle after each lookup grant; no back-pressure.
REQ-026 lookup_hit_o = sram_rdata_i[DataWidth-1] AND (sram_rdata_i[TW-1:0] == registered tag), qualified by lookup_rvalid_o; 0 otherwise.
REQ-027 Back-to-back lookups SHALL sustain one grant and one result per cycle.
REQ-028 A lookup granted in the cycle before flush entry SHALL still return its result.
REQ-029 Same-cycle refill and lookup to the same address: refill granted; retried lookup sees the new tag.
REQ-030 No internal queueing: un-granted requesters hold their request.

Reset
REQ-031 While rst_i=1: busy_o=1; sram_req_o, sram_we_o, lookup_gnt_o, refill_gnt_o, lookup_rvalid_o, lookup_hit_o = 0; sram_be_o=0; sram_addr_o=0, sram_wdata_o=0.
REQ-032 First cycle after rst_i falls SHALL write address 0.
REQ-033 rst_i mid-operation SHALL abandon any pending result and restart the full sweep from address 0.
REQ-034 busy_o SHALL fall in the cycle after the NumWords-1 write.

Verification (NumWords=64, DataWidth=8)
REQ-035 Release rst_i after 3 cycles -> 64 consecutive writes, addr 0..63, wdata 0x00, be 1; busy_o low on cycle 65; no grants.
REQ-036 Refill addr 5 tag 0x2A, then lookup addr 5 tag 0x2A -> rvalid next cycle, hit=1; lookup tag 0x2B -> hit=0.
REQ-037 Same-cycle refill addr 9 tag 0x11 + lookup addr 9 tag 0x11 -> refill_gnt=1, lookup_gnt=0; lookup granted next cycle, hit=1 one cycle later.
REQ-038 flush_req_i asserted the cycle after a lookup grant -> rvalid still pulses; 64-cycle sweep follows; lookup addr 5 tag 0x2A -> hit=0.
REQ-039 rst_i pulsed at sweep addr 30 -> sweep restarts at addr 0, busy_o held high a full 64 more cycles.
REQ-040 Lookups on 4 consecutive cycles to addr 5,6,7,8 -> 4 consecutive rvalid pulses, in order, hit only for addr 5.

Source files
------------

// File: rtl/icache_tag_sram_ctrl.sv
// Tag SRAM controller: runs an invalidate sweep after reset or flush, then arbitrates refill writes and lookups.
// A granted lookup returns its hit one cycle later. Grants are combinational, un-granted requesters hold their request, and results cannot be stalled.
module icache_tag_sram_ctrl #(
  parameter int NumWords  = 64,
  parameter int DataWidth = 8,
  localparam int AW = $clog2(NumWords),
  localparam int TW = DataWidth - 1,
  localparam int BW = (DataWidth + 7) / 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_req_i,
  output logic                 busy_o,
  input  logic                 lookup_req_i,
  output logic                 lookup_gnt_o,
  input  logic [AW-1:0]        lookup_addr_i,
  input  logic [TW-1:0]        lookup_tag_i,
  output logic                 lookup_rvalid_o,
  output logic                 lookup_hit_o,
  input  logic                 refill_req_i,
  output logic                 refill_gnt_o,
  input  logic [AW-1:0]        refill_addr_i,
  input  logic [TW-1:0]        refill_tag_i,
  output logic                 sram_req_o,
  output logic                 sram_we_o,
  output logic [AW-1:0]        sram_addr_o,
  output logic [DataWidth-1:0] sram_wdata_o,
  output logic [BW-1:0]        sram_be_o,
  input  logic [DataWidth-1:0] sram_rdata_i
);

  localparam logic [AW-1:0] LastAddr = AW'(NumWords - 1);

  typedef enum logic {ST_FLUSH, ST_IDLE} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          rvalid_q;
  logic [TW-1:0] tag_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_FLUSH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The sweep stops on the last entry instead of wrapping.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_FLUSH: begin
        if (cnt_q == LastAddr) state_d = ST_IDLE;
        else                   cnt_d   = cnt_q + AW'(1);
      end
      ST_IDLE: begin
        if (flush_req_i) begin
          state_d = ST_FLUSH;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_FLUSH;
    endcase
  end

  always_comb begin
    lookup_gnt_o = 1'b0;
    refill_gnt_o = 1'b0;
    sram_req_o   = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    if (!rst_i) begin
      case (state_q)
        ST_FLUSH: begin
          sram_req_o  = 1'b1;
          sram_we_o   = 1'b1;
          sram_addr_o = cnt_q;
        end
        ST_IDLE: begin
          if (!flush_req_i) begin
            if (refill_req_i) begin
              refill_gnt_o = 1'b1;
              sram_req_o   = 1'b1;
              sram_we_o    = 1'b1;
              sram_addr_o  = refill_addr_i;
              sram_wdata_o = {1'b1, refill_tag_i};
            end else if (lookup_req_i) begin
              lookup_gnt_o = 1'b1;
              sram_req_o   = 1'b1;
              sram_addr_o  = lookup_addr_i;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // The tag is held alongside the in-flight read so the compare lines up with rdata.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      tag_q    <= '0;
    end else begin
      rvalid_q <= lookup_gnt_o;
      if (lookup_gnt_o) tag_q <= lookup_tag_i;
    end
  end

  assign sram_be_o       = {BW{sram_req_o}};
  assign busy_o          = rst_i | (state_q == ST_FLUSH);
  assign lookup_rvalid_o = rvalid_q & ~rst_i;
  assign lookup_hit_o    = lookup_rvalid_o & sram_rdata_i[DataWidth-1] &
                           (sram_rdata_i[TW-1:0] == tag_q);

endmodule

// File: tb/tb_icache_tag_sram_ctrl.sv
// Directed bench for icache_tag_sram_ctrl with a one-cycle-latency SRAM model.
// Inputs change 1 time unit after the rising edge, and outputs are sampled on the falling edge.
module tb_icache_tag_sram_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       flush_req_i;
  logic       busy_o;
  logic       lookup_req_i;
  logic       lookup_gnt_o;
  logic [5:0] lookup_addr_i;
  logic [6:0] lookup_tag_i;
  logic       lookup_rvalid_o;
  logic       lookup_hit_o;
  logic       refill_req_i;
  logic       refill_gnt_o;
  logic [5:0] refill_addr_i;
  logic [6:0] refill_tag_i;
  logic       sram_req_o;
  logic       sram_we_o;
  logic [5:0] sram_addr_o;
  logic [7:0] sram_wdata_o;
  logic [0:0] sram_be_o;
  logic [7:0] sram_rdata_i;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem [64];

  always #5 clk_i = ~clk_i;

  icache_tag_sram_ctrl #(.NumWords(64), .DataWidth(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_req_i(flush_req_i), .busy_o(busy_o),
    .lookup_req_i(lookup_req_i), .lookup_gnt_o(lookup_gnt_o),
    .lookup_addr_i(lookup_addr_i), .lookup_tag_i(lookup_tag_i),
    .lookup_rvalid_o(lookup_rvalid_o), .lookup_hit_o(lookup_hit_o),
    .refill_req_i(refill_req_i), .refill_gnt_o(refill_gnt_o),
    .refill_addr_i(refill_addr_i), .refill_tag_i(refill_tag_i),
    .sram_req_o(sram_req_o), .sram_we_o(sram_we_o), .sram_addr_o(sram_addr_o),
    .sram_wdata_o(sram_wdata_o), .sram_be_o(sram_be_o), .sram_rdata_i(sram_rdata_i)
  );

  always @(posedge clk_i) begin
    if (sram_req_o) begin
      if (sram_we_o) mem[sram_addr_o] <= sram_wdata_o;
      else           sram_rdata_i     <= mem[sram_addr_o];
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    flush_req_i  = 1'b0;
    lookup_req_i = 1'b0;
    refill_req_i = 1'b0;
  endtask

  // Reset holds every output quiet, then 64 sweep writes run while all requesters are asserted.
  task automatic test_reset();
    logic [19:0] obs, exp;
    rst_i = 1'b1; flush_req_i = 1'b1; lookup_req_i = 1'b1; refill_req_i = 1'b1;
    lookup_addr_i = 6'd3; refill_addr_i = 6'd4; lookup_tag_i = 7'h01; refill_tag_i = 7'h02;
    for (int c = 0; c < 3; c++) begin
      tick();
      @(negedge clk_i);
      obs = {sram_req_o, sram_we_o, sram_be_o, sram_addr_o, sram_wdata_o, busy_o, lookup_gnt_o, refill_gnt_o};
      exp = {3'b000, 6'd0, 8'h00, 3'b100};
      total++;
      if (obs !== exp || lookup_rvalid_o !== 1'b0 || lookup_hit_o !== 1'b0) begin
        bad++;
        $display("FAIL reset_cycle%0d: got %h rv=%b hit=%b, want %h rv=0 hit=0", c, obs, lookup_rvalid_o, lookup_hit_o, exp);
      end
    end
    for (int k = 0; k < 64; k++) begin
      tick();
      if (k == 0) rst_i = 1'b0;
      @(negedge clk_i);
      obs = {sram_req_o, sram_we_o, sram_be_o, sram_addr_o, sram_wdata_o, busy_o, lookup_gnt_o, refill_gnt_o};
      exp = {3'b111, 6'(k), 8'h00, 3'b100};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL reset_sweep k=%0d: got %h want %h", k, obs, exp);
      end
    end
    tick();
    idle_inputs();
    @(negedge clk_i);
    total++;
    if (busy_o !== 1'b0 || sram_req_o !== 1'b0 || sram_be_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_done: busy=%b req=%b be=%b want 0 0 0", busy_o, sram_req_o, sram_be_o);
    end
  endtask

  task automatic test_refill_lookup();
    tick();
    refill_req_i = 1'b1; refill_addr_i = 6'd5; refill_tag_i = 7'h2A;
    @(negedge clk_i);
    total++;
    if ({refill_gnt_o, lookup_gnt_o, sram_req_o, sram_we_o, sram_be_o, sram_addr_o, sram_wdata_o} !== {5'b10111, 6'd5, 8'hAA}) begin
      bad++;
      $display("FAIL refill_write: gnt=%b req=%b we=%b be=%b addr=%0d wdata=%h want 1 1 1 1 5 aa",
               refill_gnt_o, sram_req_o, sram_we_o, sram_be_o, sram_addr_o, sram_wdata_o);
    end
    tick();
    refill_req_i = 1'b0; lookup_req_i = 1'b1; lookup_addr_i = 6'd5; lookup_tag_i = 7'h2A;
    @(negedge clk_i);
    total++;
    if ({lookup_gnt_o, sram_req_o, sram_we_o, sram_addr_o, lookup_rvalid_o} !== {3'b110, 6'd5, 1'b0}) begin
      bad++;
      $display("FAIL lookup_issue: gnt=%b req=%b we=%b addr=%0d rv=%b want 1 1 0 5 0",
               lookup_gnt_o, sram_req_o, sram_we_o, sram_addr_o, lookup_rvalid_o);
    end
    tick();
    lookup_tag_i = 7'h2B;
    @(negedge clk_i);
    total++;
    if ({lookup_rvalid_o, lookup_hit_o, lookup_gnt_o} !== 3'b111) begin
      bad++;
      $display("FAIL lookup_hit: rv=%b hit=%b gnt=%b want 1 1 1", lookup_rvalid_o, lookup_hit_o, lookup_gnt_o);
    end
    tick();
    lookup_req_i = 1'b0;
    @(negedge clk_i);
    total++;
    if ({lookup_rvalid_o, lookup_hit_o} !== 2'b10) begin
      bad++;
      $display("FAIL lookup_tag_miss: rv=%b hit=%b want 1 0", lookup_rvalid_o, lookup_hit_o);
    end
    tick();
    @(negedge clk_i);
    total++;
    if ({lookup_rvalid_o, lookup_hit_o} !== 2'b00) begin
      bad++;
      $display("FAIL lookup_quiet: rv=%b hit=%b want 0 0", lookup_rvalid_o, lookup_hit_o);
    end
  endtask

  task automatic test_same_cycle();
    tick();
    refill_req_i = 1'b1; refill_addr_i = 6'd9; refill_tag_i = 7'h11;
    lookup_req_i = 1'b1; lookup_addr_i = 6'd9; lookup_tag_i = 7'h11;
    @(negedge clk_i);
    total++;
    if ({refill_gnt_o, lookup_gnt_o, sram_we_o, sram_addr_o, sram_wdata_o} !== {3'b101, 6'd9, 8'h91}) begin
      bad++;
      $display("FAIL same_cycle_prio: rgnt=%b lgnt=%b we=%b addr=%0d wdata=%h want 1 0 1 9 91",
               refill_gnt_o, lookup_gnt_o, sram_we_o, sram_addr_o, sram_wdata_o);
    end
    tick();
    refill_req_i = 1'b0;
    @(negedge clk_i);
    total++;
    if ({refill_gnt_o, lookup_gnt_o, sram_we_o, sram_addr_o} !== {3'b010, 6'd9}) begin
      bad++;
      $display("FAIL same_cycle_retry: rgnt=%b lgnt=%b we=%b addr=%0d want 0 1 0 9",
               refill_gnt_o, lookup_gnt_o, sram_we_o, sram_addr_o);
    end
    tick();
    lookup_req_i = 1'b0;
    @(negedge clk_i);
    total++;
    if ({lookup_rvalid_o, lookup_hit_o} !== 2'b11) begin
      bad++;
      $display("FAIL same_cycle_hit: rv=%b hit=%b want 1 1", lookup_rvalid_o, lookup_hit_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] obs, exp;
    for (int k = 0; k < 5; k++) begin
      tick();
      lookup_req_i  = (k < 4);
      lookup_addr_i = 6'(5 + k);
      lookup_tag_i  = 7'h2A;
      @(negedge clk_i);
      obs = {lookup_gnt_o, lookup_rvalid_o, lookup_hit_o};
      exp = {k < 4, k >= 1, k == 1};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL back_to_back k=%0d: gnt/rv/hit got %b want %b", k, obs, exp);
      end
    end
    tick();
    lookup_req_i = 1'b0;
  endtask

  task automatic test_flush();
    logic [19:0] obs, exp;
    lookup_req_i = 1'b1; lookup_addr_i = 6'd5; lookup_tag_i = 7'h2A;
    @(negedge clk_i);
    total++;
    if (lookup_gnt_o !== 1'b1) begin
      bad++;
      $display("FAIL flush_pre_lookup: gnt=%b want 1", lookup_gnt_o);
    end
    tick();
    lookup_req_i = 1'b0; flush_req_i = 1'b1;
    @(negedge clk_i);
    total++;
    if ({lookup_rvalid_o, lookup_hit_o, lookup_gnt_o, refill_gnt_o, sram_req_o} !== 5'b11000) begin
      bad++;
      $display("FAIL flush_result: rv=%b hit=%b lgnt=%b rgnt=%b req=%b want 1 1 0 0 0",
               lookup_rvalid_o, lookup_hit_o, lookup_gnt_o, refill_gnt_o, sram_req_o);
    end
    for (int k = 0; k < 64; k++) begin
      tick();
      flush_req_i = 1'b0;
      @(negedge clk_i);
      obs = {sram_req_o, sram_we_o, sram_be_o, sram_addr_o, sram_wdata_o, busy_o, lookup_gnt_o, refill_gnt_o};
      exp = {3'b111, 6'(k), 8'h00, 3'b100};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL flush_sweep k=%0d: got %h want %h", k, obs, exp);
      end
    end
    tick();
    lookup_req_i = 1'b1; lookup_addr_i = 6'd5; lookup_tag_i = 7'h2A;
    @(negedge clk_i);
    total++;
    if ({busy_o, lookup_gnt_o} !== 2'b01) begin
      bad++;
      $display("FAIL flush_done: busy=%b gnt=%b want 0 1", busy_o, lookup_gnt_o);
    end
    tick();
    lookup_req_i = 1'b0;
    @(negedge clk_i);
    total++;
    if ({lookup_rvalid_o, lookup_hit_o} !== 2'b10) begin
      bad++;
      $display("FAIL flush_invalidated: rv=%b hit=%b want 1 0", lookup_rvalid_o, lookup_hit_o);
    end
  endtask

  task automatic test_mid_reset();
    tick();
    lookup_req_i = 1'b1; lookup_addr_i = 6'd9; lookup_tag_i = 7'h11;
    @(negedge clk_i);
    total++;
    if (lookup_gnt_o !== 1'b1) begin
      bad++;
      $display("FAIL midrst_lookup: gnt=%b want 1", lookup_gnt_o);
    end
    tick();
    lookup_req_i = 1'b0; rst_i = 1'b1;
    @(negedge clk_i);
    total++;
    if ({lookup_rvalid_o, lookup_hit_o, busy_o, sram_req_o} !== 4'b0010) begin
      bad++;
      $display("FAIL midrst_abandon: rv=%b hit=%b busy=%b req=%b want 0 0 1 0",
               lookup_rvalid_o, lookup_hit_o, busy_o, sram_req_o);
    end
    for (int k = 0; k <= 30; k++) begin
      tick();
      rst_i = (k == 30);
      @(negedge clk_i);
      total++;
      if (k < 30 && {sram_req_o, busy_o, sram_addr_o} !== {2'b11, 6'(k)}) begin
        bad++;
        $display("FAIL midrst_first k=%0d: req=%b busy=%b addr=%0d want 1 1 %0d", k, sram_req_o, busy_o, sram_addr_o, k);
      end else if (k == 30 && {sram_req_o, busy_o, sram_addr_o} !== {2'b01, 6'd0}) begin
        bad++;
        $display("FAIL midrst_pulse: req=%b busy=%b addr=%0d want 0 1 0", sram_req_o, busy_o, sram_addr_o);
      end
    end
    for (int k = 0; k < 64; k++) begin
      tick();
      rst_i = 1'b0;
      @(negedge clk_i);
      total++;
      if ({sram_req_o, sram_we_o, busy_o, sram_addr_o} !== {3'b111, 6'(k)}) begin
        bad++;
        $display("FAIL midrst_resweep k=%0d: req=%b we=%b busy=%b addr=%0d", k, sram_req_o, sram_we_o, busy_o, sram_addr_o);
      end
    end
    tick();
    @(negedge clk_i);
    total++;
    if (busy_o !== 1'b0) begin
      bad++;
      $display("FAIL midrst_done: busy=%b want 0", busy_o);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'hFF;
    sram_rdata_i = 8'h00;
    rst_i = 1'b1;
    idle_inputs();
    lookup_addr_i = '0; lookup_tag_i = '0; refill_addr_i = '0; refill_tag_i = '0;
    test_reset();
    test_refill_lookup();
    test_same_cycle();
    test_back_to_back();
    test_flush();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
